// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM state
// codes and the datapath select values driven by the output decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_IDLE    = 4'd15
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_control_out_decode.sv
// Combinational datapath control decode from the current FSM state; only the
// PC enable, IR load and store completion look at zero / mem_ready.
module mips_control_out_decode
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done
);

  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        i_or_d = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      // Write strobe stays up across stalls; the store retires when memory acks.
      S_MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, opcode
// driven sequencing and the retired-instruction counter.
//
// state   | meaning
// IDLE    | after reset, all controls low, goes to FETCH
// FETCH   | read instruction at PC, PC+4, wait for mem_ready
// DECODE  | read registers, precompute branch target, dispatch on opcode
// MEMADR  | lw/sw effective address
// MEMRD   | load data read, wait for mem_ready
// MEMWB   | load data written to rt
// MEMWR   | store, write held until mem_ready
// EXECUTE | R-type ALU operation
// ALUWB   | R-type result written to rd
// BRANCH  | beq compare, PC <- target when zero
// ADDIEX  | addi ALU operation
// ADDIWB  | addi result written to rt
// JUMP    | PC <- jump target
// 12..14  | unused codes, fall back to FETCH
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (instr_done) cnt_d = cnt_q + CNT_W'(1);
  end

  mips_control_out_decode u_out_decode (
    .state      (state_q),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done)
  );

  assign illegal_op  = (state_q == S_DECODE) && !op_legal(opcode);
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback states from the instruction opcode. It produces the 2-bit alu_op consumed by the ALU control decoder, plus all datapath mux selects and write enables. It also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory access complete this cycle
pc_en  output  1  PC load enable
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_write  output  1  memory write enable
ir_write  output  1  instruction register load
reg_dst  output  1  write register: 0=rt, 1=rd
mem_to_reg  output  1  write data: 0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=regA
alu_src_b  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=use funct
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
illegal_op  output  1  one-cycle pulse in DECODE when opcode is unsupported
state  output  4  current state, for debug
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). The polarity and synchronicity are fixed.
- Reset: state=IDLE and instr_count=0. In IDLE all outputs are 0. IDLE goes to FETCH on the next clock unconditionally.
- Reset mid-instruction: abort immediately to IDLE. Any in-flight write enable drops asynchronously.
- Outputs are Moore, decoded from state. The exceptions are pc_en (also uses zero and mem_ready) and the writes gated by mem_ready.
- Encodings: IDLE=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-14 recover to FETCH with all outputs 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Unlisted outputs are 0 in each state below.
- FETCH: alu_src_b=01, ir_write=mem_ready, pc_en=mem_ready. Stay while mem_ready=0, else go to DECODE.
- DECODE: alu_src_b=11. Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXECUTE
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - other -> FETCH, with illegal_op=1
- MEMADR: alu_src_a=1, alu_src_b=10. lw -> MEMRD, sw -> MEMWR.
- MEMRD: i_or_d=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Go to FETCH.
- MEMWR: i_or_d=1, mem_write=1 held. instr_done=mem_ready. Leave to FETCH on the first cycle with mem_ready=1.
- EXECUTE: alu_src_a=1, alu_op=10. Go to ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Go to ADDIWB.
- ADDIWB: reg_write=1, instr_done=1. Go to FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Go to FETCH.
- Latency with mem_ready always 1, FETCH to last cycle inclusive:
  - lw 5
  - R 4, sw 4, addi 4
  - beq 3, j 3
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- instr_count increments on each clock edge where instr_done=1. It wraps from all-ones to 0. An illegal opcode does not count.
- opcode is sampled only in DECODE and MEMADR. Changes elsewhere are ignored.

Decomposition:
- mips_pkg holds:
  - opcode constants
  - state encodings
  - alu_op constants ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10
  - alu_src_b and pc_src select constants
- One natural sub-module, mips_control_out_decode: a combinational state/zero/mem_ready to output decoder.
- The top level holds the state register, next-state logic and counter.

Test Plan:
- Reset then release, mem_ready=1, opcode=000000: states 15,0,1,6,7. In ALUWB, reg_dst=1, reg_write=1, alu_op=10 (in EXECUTE), instr_done=1. instr_count=1.
- lw (100011) with mem_ready low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4. mem_to_reg=1 and reg_write=1 only in state 4. Total 7 cycles.
- beq (000100) run twice, zero=1 then zero=0: pc_en=1 with pc_src=01 in BRANCH the first time, pc_en=0 the second time. alu_op=01 both times.
- sw (101011) with mem_ready=0 for 1 cycle in MEMWR: mem_write held high for 2 cycles. instr_done pulses once. Return to FETCH.
- Illegal opcode 111111: illegal_op pulses in DECODE and the next state is FETCH. instr_count is unchanged.
- Counter wrap and reset abort, with CNT_W=4:
  - 16 R-type instructions give instr_count=0.
  - Asserting rst_n=0 during MEMWR forces mem_write=0 and state=15 immediately, without waiting for a clock edge.
